// File: rtl/window_stats_if.sv
`default_nettype none
// ============================================================================
// Module   : window_stats_if
// Brief    : Window-in / statistics-out handshake bundle for window_stats_ctrl.
// Revision : 1.0
// ============================================================================
interface window_stats_if #(
    parameter int WS_I = 8,
    parameter int WS_J = 8,
    parameter int BYTE = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [WS_I*WS_J*BYTE-1:0]  in_window;
    logic [7:0]                 var_threshold;
    logic                       out_valid;
    logic                       out_ready;
    logic [7:0]                 out_mean;
    logic [7:0]                 out_var;
    logic                       out_flat;
    logic                       out_err;

    modport master (
        output in_valid, in_window, var_threshold, out_ready,
        input  in_ready, out_valid, out_mean, out_var, out_flat, out_err
    );

    modport slave (
        input  in_valid, in_window, var_threshold, out_ready,
        output in_ready, out_valid, out_mean, out_var, out_flat, out_err
    );
endinterface
`default_nettype wire

// File: rtl/window_stats_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : window_stats_ctrl
// Brief    : Sequences mean then variance units over one pixel window and
//            reports mean, variance, flatness and timeout error.
// Revision : 1.0
// ============================================================================
module window_stats_ctrl #(
    parameter int WS_I    = 8,
    parameter int WS_J    = 8,
    parameter int BYTE    = 8,
    parameter int TIMEOUT = 255
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    window_stats_if.slave                   s,
    output logic                            mean_rst,
    output logic [WS_I*WS_J*BYTE-1:0]       mean_values,
    output logic                            mean_input_valid,
    input  wire logic [7:0]                 mean_value,
    input  wire logic                       mean_output_valid,
    output logic                            var_rst,
    output logic [WS_I*WS_J*BYTE-1:0]       var_values,
    output logic [7:0]                      var_mean_value,
    output logic                            var_input_valid,
    input  wire logic [7:0]                 var_value,
    input  wire logic                       var_output_valid
);

    localparam int c_cnt_bits = $clog2(TIMEOUT + 1);
    localparam int c_cnt_w    = (c_cnt_bits > 8) ? c_cnt_bits : 8;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEAN = 2'd1,
        ST_VAR  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                         r_state;
    logic [WS_I*WS_J*BYTE-1:0]      r_window;
    logic [7:0]                     r_thr;
    logic [7:0]                     r_mean;
    logic [7:0]                     r_var;
    logic                           r_flat;
    logic                           r_err;
    logic [c_cnt_w-1:0]             r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_window <= '0;
            r_thr    <= '0;
            r_mean   <= '0;
            r_var    <= '0;
            r_flat   <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s.in_valid) begin
                        // Results from the previous window are cleared so an
                        // aborted sub-operation reports 0 for what it missed.
                        r_window <= s.in_window;
                        r_thr    <= s.var_threshold;
                        r_mean   <= '0;
                        r_var    <= '0;
                        r_flat   <= 1'b0;
                        r_err    <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= ST_MEAN;
                    end
                end
                ST_MEAN: begin
                    if (mean_output_valid) begin
                        r_mean  <= mean_value;
                        r_cnt   <= '0;
                        r_state <= ST_VAR;
                    end else if (r_cnt == c_cnt_last) begin
                        r_err   <= 1'b1;
                        r_flat  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_VAR: begin
                    // A response in the final wait cycle still counts as good.
                    if (var_output_valid) begin
                        r_var   <= var_value;
                        r_flat  <= (var_value <= r_thr);
                        r_err   <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (r_cnt == c_cnt_last) begin
                        r_err   <= 1'b1;
                        r_flat  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (s.out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s.in_ready        = (r_state == ST_IDLE);
    assign s.out_valid       = (r_state == ST_DONE);
    assign s.out_mean        = r_mean;
    assign s.out_var         = r_var;
    assign s.out_flat        = r_flat;
    assign s.out_err         = r_err;

    // Units are held in reset outside their own phase so each starts clean.
    assign mean_rst          = rst | (r_state != ST_MEAN);
    assign var_rst           = rst | (r_state != ST_VAR);
    assign mean_input_valid  = (r_state == ST_MEAN);
    assign var_input_valid   = (r_state == ST_VAR);
    assign mean_values       = r_window;
    assign var_values        = r_window;
    assign var_mean_value    = r_mean;

endmodule
`default_nettype wire
